// File: rtl/riffa_pipe_pkg.sv
// Shared definitions for the RIFFA retiming pipeline blocks.
package riffa_pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 16;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ff_pipeline_stage.sv
// One register slot of ff_pipeline: loads on transfer, empties when drained, holds when blocked.
module ff_pipeline_stage #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    input  logic             NEXT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    output logic             READY
);

    // An empty slot always accepts, which is what lets bubbles collapse under backpressure.
    assign READY = !OUT_VALID || NEXT_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (READY) begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID) begin
                OUT_DATA <= IN_DATA;
            end
        end
    end

endmodule

// File: rtl/ff_pipeline.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, flush and an occupancy counter.
module ff_pipeline
    import riffa_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         FLUSH,
    input  logic [WIDTH-1:0]             WR_DATA,
    input  logic                         WR_VALID,
    output logic                         WR_READY,
    output logic [WIDTH-1:0]             RD_DATA,
    output logic                         RD_VALID,
    input  logic                         RD_READY,
    output logic [cnt_width(DEPTH)-1:0]  COUNT
);

    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("ff_pipeline: DEPTH out of range 1..16");
    end

    // Each slot's wiring lives in its own generate scope so the ready chain is a set of
    // distinct nets rather than bits of one vector feeding back on itself.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dq;
        logic             vin;
        logic             vq;
        logic             nrdy;
        logic             rdy;

        if (i == 0) begin : g_head
            assign din = WR_DATA;
            assign vin = WR_VALID;
        end else begin : g_body
            assign din = g_stage[i-1].dq;
            assign vin = g_stage[i-1].vq;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign nrdy = RD_READY;
        end else begin : g_link
            assign nrdy = g_stage[i+1].rdy;
        end

        ff_pipeline_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .FLUSH      (FLUSH),
            .IN_DATA    (din),
            .IN_VALID   (vin),
            .NEXT_READY (nrdy),
            .OUT_DATA   (dq),
            .OUT_VALID  (vq),
            .READY      (rdy)
        );
    end

    assign WR_READY = g_stage[0].rdy && !FLUSH;
    assign RD_DATA  = g_stage[DEPTH-1].dq;
    assign RD_VALID = g_stage[DEPTH-1].vq;

    logic in_hs;
    logic out_hs;

    assign in_hs  = WR_VALID && WR_READY;
    assign out_hs = RD_VALID && RD_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            COUNT <= '0;
        end else if (FLUSH) begin
            COUNT <= '0;
        end else begin
            case ({in_hs, out_hs})
                2'b10:   COUNT <= COUNT + CW'(1);
                2'b01:   COUNT <= COUNT - CW'(1);
                default: COUNT <= COUNT;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge CLK) disable iff (!RST_N)
        COUNT <= CW'(DEPTH));

    a_hold_data: assert property (@(posedge CLK) disable iff (!RST_N)
        RD_VALID && !RD_READY |=> $stable(RD_DATA));

endmodule

// File: tb/tb_ff_pipeline.sv
// Scoreboard bench for ff_pipeline: directed cases on DEPTH 3/4, random soak on DEPTH 1/16.
module tb_ff_pipeline;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       fl4, wv4, wr4, rv4, rr4;
    logic [7:0] wd4, rd4;
    logic [2:0] cnt4;

    logic       fl3, wv3, wr3, rv3, rr3;
    logic [7:0] wd3, rd3;
    logic [1:0] cnt3;

    logic       fl1, wv1, wr1, rv1, rr1;
    logic [7:0] wd1, rd1;
    logic [0:0] cnt1;

    logic       fl16, wv16, wr16, rv16, rr16;
    logic [7:0] wd16, rd16;
    logic [4:0] cnt16;

    ff_pipeline #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(fl4), .WR_DATA(wd4), .WR_VALID(wv4), .WR_READY(wr4),
        .RD_DATA(rd4), .RD_VALID(rv4), .RD_READY(rr4), .COUNT(cnt4));

    ff_pipeline #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(fl3), .WR_DATA(wd3), .WR_VALID(wv3), .WR_READY(wr3),
        .RD_DATA(rd3), .RD_VALID(rv3), .RD_READY(rr3), .COUNT(cnt3));

    ff_pipeline #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(fl1), .WR_DATA(wd1), .WR_VALID(wv1), .WR_READY(wr1),
        .RD_DATA(rd1), .RD_VALID(rv1), .RD_READY(rr1), .COUNT(cnt1));

    ff_pipeline #(.WIDTH(8), .DEPTH(16)) u_d16 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(fl16), .WR_DATA(wd16), .WR_VALID(wv16), .WR_READY(wr16),
        .RD_DATA(rd16), .RD_VALID(rv16), .RD_READY(rr16), .COUNT(cnt16));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0] q4[$];
    logic [7:0] q3[$];
    logic [7:0] q1[$];
    logic [7:0] q16[$];
    int         cyc4_n = 0;
    logic       wr_s4, rv_s4, hs_out4;
    logic [7:0] rd_s4;

    // One DEPTH-4 cycle: drive after the falling edge, sample and score before the rising edge.
    task automatic cyc4(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
        @(negedge clk);
        wv4 = wv; wd4 = wd; rr4 = rr; fl4 = fl;
        #1;
        wr_s4 = wr4; rv_s4 = rv4; rd_s4 = rd4;
        check("d4.count", 32'(cnt4), 32'(q4.size()));
        hs_out4 = rv4 && rr4;
        if (hs_out4) begin
            if (q4.size() == 0) check("d4.extra_word", 32'(rv4), 32'd0);
            else                check("d4.rd_data", 32'(rd4), 32'(q4.pop_front()));
        end
        if (fl)                   q4.delete();
        else if (wv4 && wr4)      q4.push_back(wd);
        cyc4_n++;
    endtask

    task automatic drain4(input string tag);
        for (int k = 0; k < 24 && q4.size() > 0; k++) cyc4(1'b0, 8'h00, 1'b1, 1'b0);
        check(tag, 32'(q4.size()), 32'd0);
    endtask

    int t_in;
    int outs[$];

    initial begin
        {fl4, wv4, rr4, wd4} = '0;
        {fl3, wv3, rr3, wd3} = '0;
        {fl1, wv1, rr1, wd1} = '0;
        {fl16, wv16, rr16, wd16} = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst.wr_ready", 32'(wr4), 32'd1);
        check("rst.rd_valid", 32'(rv4), 32'd0);
        check("rst.rd_data", 32'(rd4), 32'd0);
        check("rst.count", 32'(cnt4), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // streaming latency and throughput
        for (int k = 0; k < 8; k++) begin
            cyc4(1'b1, 8'(k + 1), 1'b1, 1'b0);
            check("stream.wr_ready", 32'(wr_s4), 32'd1);
            if (k == 0) t_in = cyc4_n - 1;
            if (hs_out4) outs.push_back(cyc4_n - 1);
        end
        for (int k = 0; k < 12 && q4.size() > 0; k++) begin
            cyc4(1'b0, 8'h00, 1'b1, 1'b0);
            if (hs_out4) outs.push_back(cyc4_n - 1);
        end
        check("stream.words_out", 32'(outs.size()), 32'd8);
        if (outs.size() > 0) check("stream.latency", 32'(outs[0] - t_in), 32'd4);
        for (int j = 1; j < outs.size(); j++) check("stream.spacing", 32'(outs[j] - outs[j-1]), 32'd1);

        // fill under backpressure
        for (int k = 0; k < 6; k++) begin
            cyc4(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
            check("fill.wr_ready", 32'(wr_s4), (k < 4) ? 32'd1 : 32'd0);
        end
        cyc4(1'b1, 8'h3f, 1'b1, 1'b0);
        check("fill.passthru_ready", 32'(wr_s4), 32'd1);
        drain4("fill.drain");

        // bubble collapse
        cyc4(1'b1, 8'h10, 1'b0, 1'b0);
        repeat (2) cyc4(1'b0, 8'h00, 1'b0, 1'b0);
        cyc4(1'b1, 8'h20, 1'b0, 1'b0);
        repeat (4) cyc4(1'b0, 8'h00, 1'b0, 1'b0);
        check("bubble.rd_valid", 32'(rv_s4), 32'd1);
        check("bubble.head", 32'(rd_s4), 32'h10);
        cyc4(1'b1, 8'h30, 1'b0, 1'b0);
        check("bubble.accept3", 32'(wr_s4), 32'd1);
        cyc4(1'b1, 8'h40, 1'b0, 1'b0);
        check("bubble.accept4", 32'(wr_s4), 32'd1);
        cyc4(1'b1, 8'h50, 1'b0, 1'b0);
        check("bubble.full", 32'(wr_s4), 32'd0);
        drain4("bubble.drain");

        // flush with a word offered
        for (int k = 0; k < 3; k++) cyc4(1'b1, 8'(8'h61 + k), 1'b0, 1'b0);
        cyc4(1'b0, 8'h00, 1'b0, 1'b0);
        cyc4(1'b1, 8'h64, 1'b0, 1'b1);
        check("flush.wr_ready", 32'(wr_s4), 32'd0);
        cyc4(1'b0, 8'h00, 1'b0, 1'b0);
        check("flush.rd_valid", 32'(rv_s4), 32'd0);
        cyc4(1'b1, 8'h77, 1'b1, 1'b0);
        drain4("flush.recover");

        // random soak, DEPTH 1 and DEPTH 16 side by side, with rare flushes
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            wv1  = 1'($urandom_range(0, 1));  wd1  = 8'($urandom);
            rr1  = 1'($urandom_range(0, 1));  fl1  = ($urandom_range(0, 255) == 0);
            wv16 = 1'($urandom_range(0, 1));  wd16 = 8'($urandom);
            rr16 = 1'($urandom_range(0, 2) == 0 ? 0 : 1);
            fl16 = ($urandom_range(0, 255) == 0);
            #1;
            check("d1.count", 32'(cnt1), 32'(q1.size()));
            check("d1.wr_ready", 32'(wr1), 32'((q1.size() < 1 || rr1) && !fl1));
            if (rv1 && rr1) begin
                if (q1.size() == 0) check("d1.extra_word", 32'(rv1), 32'd0);
                else                check("d1.rd_data", 32'(rd1), 32'(q1.pop_front()));
            end
            if (fl1) q1.delete();
            else if (wv1 && wr1) q1.push_back(wd1);

            check("d16.count", 32'(cnt16), 32'(q16.size()));
            check("d16.wr_ready", 32'(wr16), 32'((q16.size() < 16 || rr16) && !fl16));
            if (rv16 && rr16) begin
                if (q16.size() == 0) check("d16.extra_word", 32'(rv16), 32'd0);
                else                 check("d16.rd_data", 32'(rd16), 32'(q16.pop_front()));
            end
            if (fl16) q16.delete();
            else if (wv16 && wr16) q16.push_back(wd16);
        end
        @(negedge clk);
        {wv1, fl1, wv16, fl16} = '0;
        {rr1, rr16} = 2'b11;

        // asynchronous reset mid-stream on DEPTH 3
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wv3 = 1'b1; wd3 = 8'(8'ha1 + k); rr3 = 1'b0;
            #1;
            check("d3.wr_ready", 32'(wr3), 32'd1);
            q3.push_back(wd3);
        end
        @(negedge clk);
        wv3 = 1'b0;
        #1;
        check("d3.count_full", 32'(cnt3), 32'(q3.size()));
        check("d3.rd_valid_full", 32'(rv3), 32'd1);
        check("d3.head", 32'(rd3), 32'(q3[0]));
        #1 rst_n = 1'b0;
        #1;
        check("d3.rst_rd_valid", 32'(rv3), 32'd0);
        check("d3.rst_rd_data", 32'(rd3), 32'd0);
        check("d3.rst_count", 32'(cnt3), 32'd0);
        check("d3.rst_wr_ready", 32'(wr3), 32'd1);
        q3.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rr3 = 1'b1;
            #1;
            check("d3.no_ghost", 32'(rv3), 32'(q3.size() > 0));
            check("d3.count_after", 32'(cnt3), 32'(q3.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ff_pipeline.md
# ff_pipeline

Parametrised register pipeline, the multi-bit, multi-stage successor to the single-bit `ff` flip-flop. It carries a `WIDTH`-bit word through `DEPTH` register stages with a valid/ready handshake. Idle stages collapse, so bubbles are absorbed under backpressure. It sits on long datapaths between RIFFA channel logic and the PCIe-side engines, where timing closure needs retiming registers that must also honour flow control.

## Interface
- `WIDTH`, default 32: data width in bits, ≥1.
- `DEPTH`, default 2: number of register stages, 1..16.
- `CLK` input, 1 bit: sole clock; all state updates on the rising edge.
- `RST_N` input, 1 bit: reset, asynchronous, active-low.
- `FLUSH` input, 1 bit: synchronous; discards all held words.
- `WR_DATA` input, `WIDTH` bits: upstream data.
- `WR_VALID` input, 1 bit: upstream word present.
- `WR_READY` output, 1 bit: pipeline accepts `WR_DATA` this cycle.
- `RD_DATA` output, `WIDTH` bits: data of the last stage.
- `RD_VALID` output, 1 bit: last stage holds a word.
- `RD_READY` input, 1 bit: downstream accepts `RD_DATA` this cycle.
- `COUNT` output, `$clog2(DEPTH+1)` bits: number of valid words held.

## Operation
- Stage state: `v[i]` (valid) and `d[i]` (data) for i = 0..`DEPTH`-1. Stage 0 faces upstream; stage `DEPTH`-1 drives `RD_DATA`/`RD_VALID`.
- Per-stage ready:
  - `r[DEPTH]` = `RD_READY`.
  - `r[i]` = `!v[i] || r[i+1]`.
  - `WR_READY` = `r[0] && !FLUSH`.
- Transfer into stage i occurs when `r[i]` is high and the source is valid. The source is `WR_VALID` for i=0 and `v[i-1]` otherwise.
  - On transfer: `d[i]` ← source data, `v[i]` ← 1.
  - When `r[i]` is high with no valid source: `v[i]` ← 0, `d[i]` holds.
  - When `r[i]` is low: the stage holds.
- Data registers load only on transfer. No combinational data path from `WR_DATA` to `RD_DATA`.
- A word is never duplicated or dropped. Words leave in arrival order.
- `COUNT` is a registered counter, not a popcount:
  - +1 on an input handshake (`WR_VALID && WR_READY`).
  - −1 on an output handshake (`RD_VALID && RD_READY`).
  - Unchanged when both occur in the same cycle.
  - Never exceeds `DEPTH`.
- `FLUSH` overrides every other update that cycle:
  - All `v[i]` ← 0 and `COUNT` ← 0; `d[i]` holds.
  - `WR_READY` is 0 during `FLUSH`.
  - An output handshake in the flush cycle still counts as delivered to downstream.
- Reset (`RST_N` low, any time, including mid-transfer):
  - Immediately forces all `v[i]`=0, all `d[i]`=0, `COUNT`=0.
  - Outputs: `RD_VALID`=0, `RD_DATA`=0, `COUNT`=0.
  - `WR_READY`=1 unless `FLUSH` is high.
  - Words in flight are lost.
  - Deassertion is not synchronised internally; the reset-synchroniser upstream guarantees clean release.

## Timing
- Latency from input handshake to `RD_VALID`, empty pipeline, `RD_READY` held high: `DEPTH` cycles.
- Throughput with `RD_READY` high: one word per cycle, sustained.
- Full pipeline (`COUNT`=`DEPTH`) with `RD_READY`=0: `WR_READY`=0 in the same cycle.
- Full pipeline with `RD_READY`=1: `WR_READY`=1 in the same cycle (pass-through ready). The path from `RD_READY` to `WR_READY` is combinational through `DEPTH` AND/OR levels; this is accepted.
- Bubble collapse: with `RD_READY` low, a partially filled pipeline keeps accepting words until `COUNT`=`DEPTH`.
- `RD_DATA` is stable while `RD_VALID`=1 and `RD_READY`=0.

## Structure
- Shared package `riffa_pipe_pkg`:
  - function `cnt_width(depth)` returning `$clog2(depth+1)`.
  - localparam `PIPE_MAX_DEPTH` = 16, used by the elaboration-time assertion on `DEPTH`.
- Sub-module `ff_pipeline_stage`:
  - Ports: `CLK`, `RST_N`, `FLUSH`, data/valid in, ready in from the next stage, data/valid out, ready out.
  - Instantiated `DEPTH` times in a generate loop.
- `COUNT` logic lives in the top level.

## Test plan
- Reset mid-stream: `DEPTH`=3, three words 0xA1..0xA3 in flight, pull `RST_N` low between clock edges → `RD_VALID`, `RD_DATA`, `COUNT` go to 0 immediately, without waiting for an edge; no word emerges after release.
- Streaming latency: `DEPTH`=4, `RD_READY`=1, words 1..8 on consecutive cycles → word 1 appears 4 cycles after its handshake, then words 2..8 on consecutive cycles, with `COUNT` steady at 4.
- Fill under backpressure: `DEPTH`=4, `RD_READY`=0, `WR_VALID`=1 constantly → exactly 4 words accepted, `WR_READY`=0 from cycle 4, `COUNT`=4; raise `RD_READY` → `WR_READY`=1 the same cycle, order preserved.
- Bubble collapse: `DEPTH`=4, send words 0x10 and 0x20 with gaps while `RD_READY`=0 → both held adjacent, `COUNT`=2, 0x10 emerges first.
- Flush: `COUNT`=3, assert `FLUSH` with `WR_VALID`=1 → no input accepted that cycle, `COUNT`=0 and `RD_VALID`=0 next cycle.
- Randomised soak: `WIDTH`=8, `DEPTH`=1 and `DEPTH`=16, random valid/ready for 10k cycles → scoreboard shows no loss or duplication, and `COUNT` equals the scoreboard occupancy every cycle.
